pe_feeder: RTL and testbench

//  Issue side of the parallel_pe stream. On start, reads neuron and weight sub-vectors from the

---
 rtl/pe_feeder.sv | 189 ++++++++++++++++++
 tb/tb_pe_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: issue side of one parallel_pe. Walks the neuron/weight buffers for
// every (output neuron, sub-vector) pair, hands the beats to the PE and writes
// the returned dot products into the result buffer, then pulses done.
//
// Handshake: pe_vld and pe_res_vld are valid-only qualifiers with no ready in
// either direction. The PE cannot push back, so stall only withholds new buffer
// reads; every beat already read is forwarded the following cycle.
module pe_feeder #(
  parameter int DW = 512,
  parameter int AW = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cfg_sub_num,
  input  logic [CW-1:0] cfg_out_num,
  input  logic [AW-1:0] cfg_nbase,
  input  logic [AW-1:0] cfg_wbase,
  input  logic [AW-1:0] cfg_rbase,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          nbuf_rd_en,
  output logic [AW-1:0] nbuf_rd_addr,
  input  logic [DW-1:0] nbuf_rd_data,
  output logic          wbuf_rd_en,
  output logic [AW-1:0] wbuf_rd_addr,
  input  logic [DW-1:0] wbuf_rd_data,
  output logic [DW-1:0] pe_neuron,
  output logic [DW-1:0] pe_weight,
  output logic [1:0]    pe_ctrl,
  output logic          pe_vld,
  input  logic [31:0]   pe_res,
  input  logic          pe_res_vld,
  output logic          res_wr_en,
  output logic [AW-1:0] res_wr_addr,
  output logic [31:0]   res_wr_data,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Job configuration latched on an accepted start
  logic [CW-1:0] sub_q;
  logic [CW-1:0] out_q;
  logic [AW-1:0] nbase_q;
  logic [AW-1:0] rbase_q;

  // Issue position and result progress
  logic [CW-1:0] s_cnt;
  logic [CW-1:0] o_cnt;
  logic [CW-1:0] res_cnt;
  logic [AW-1:0] wptr;

  logic       accept;
  logic       issue;
  logic       last_s;
  logic       last_o;
  logic       capture;
  logic [1:0] rd_ctrl;

  // start is only honoured when fully idle (busy still covers the done cycle)
  assign accept  = start && (state == IDLE) && !busy;
  assign issue   = (state == ISSUE) && !stall;
  assign last_s  = (s_cnt == (sub_q - CW'(1)));
  assign last_o  = (o_cnt == (out_q - CW'(1)));
  assign rd_ctrl = {last_s, (s_cnt == '0)};
  // Results only count while a job is in flight
  assign capture = pe_res_vld && ((state == ISSUE) || (state == WAIT));

  // Reads are issued in the same cycle the decision is made so stall acts immediately
  assign nbuf_rd_en   = issue;
  assign wbuf_rd_en   = issue;
  assign nbuf_rd_addr = nbase_q + AW'(s_cnt);
  assign wbuf_rd_addr = wptr;

  // Buffer data lines up with pe_vld because both trail the read by one cycle
  assign pe_neuron = nbuf_rd_data;
  assign pe_weight = wbuf_rd_data;

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (cfg_out_num == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (issue && last_s && last_o) state_nxt = WAIT;
      end
      WAIT: begin
        if (res_cnt == out_q) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration capture and issue counters; wptr runs linearly across outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      out_q   <= '0;
      nbase_q <= '0;
      rbase_q <= '0;
      wptr    <= '0;
      s_cnt   <= '0;
      o_cnt   <= '0;
    end else if (accept) begin
      sub_q   <= (cfg_sub_num == '0) ? CW'(1) : cfg_sub_num;
      out_q   <= cfg_out_num;
      nbase_q <= cfg_nbase;
      rbase_q <= cfg_rbase;
      wptr    <= cfg_wbase;
      s_cnt   <= '0;
      o_cnt   <= '0;
    end else if (issue) begin
      wptr <= wptr + AW'(1);
      if (last_s) begin
        s_cnt <= '0;
        o_cnt <= o_cnt + CW'(1);
      end else begin
        s_cnt <= s_cnt + CW'(1);
      end
    end
  end

  // One-cycle issue pipeline towards the PE; ctrl is forced to 0 on bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_vld  <= 1'b0;
      pe_ctrl <= 2'b00;
    end else begin
      pe_vld  <= issue;
      pe_ctrl <= issue ? rd_ctrl : 2'b00;
    end
  end

  // Result capture; results arrive in output order so the count is the offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      res_cnt     <= '0;
    end else begin
      res_wr_en <= capture;
      if (capture) begin
        res_wr_addr <= rbase_q + AW'(res_cnt);
        res_wr_data <= pe_res;
        res_cnt     <= res_cnt + CW'(1);
      end else if (accept) begin
        res_cnt <= '0;
      end
    end
  end

  // Status: busy from the cycle after start through the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: buffer models, a stand-in PE with random result latency,
// a job-level reference model feeding expected queues, and a table of jobs.
module tb_pe_feeder;
  localparam int DW = 512;
  localparam int AW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_sub_num, cfg_out_num;
  logic [AW-1:0] cfg_nbase, cfg_wbase, cfg_rbase;
  logic          stall;
  logic          busy, done;
  logic          nbuf_rd_en, wbuf_rd_en;
  logic [AW-1:0] nbuf_rd_addr, wbuf_rd_addr;
  logic [DW-1:0] nbuf_rd_data, wbuf_rd_data;
  logic [DW-1:0] pe_neuron, pe_weight;
  logic [1:0]    pe_ctrl;
  logic          pe_vld;
  logic [31:0]   pe_res;
  logic          pe_res_vld;
  logic          res_wr_en;
  logic [AW-1:0] res_wr_addr;
  logic [31:0]   res_wr_data;
  logic [1:0]    dbg_state;

  pe_feeder #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_sub_num(cfg_sub_num), .cfg_out_num(cfg_out_num),
    .cfg_nbase(cfg_nbase), .cfg_wbase(cfg_wbase), .cfg_rbase(cfg_rbase),
    .stall(stall), .busy(busy), .done(done),
    .nbuf_rd_en(nbuf_rd_en), .nbuf_rd_addr(nbuf_rd_addr), .nbuf_rd_data(nbuf_rd_data),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr), .wbuf_rd_data(wbuf_rd_data),
    .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctrl(pe_ctrl), .pe_vld(pe_vld),
    .pe_res(pe_res), .pe_res_vld(pe_res_vld),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [2*AW-1:0] exp_rd_q[$];
  logic [1:0]      exp_ctrl_q[$];
  logic [AW+31:0]  exp_wr_q[$];
  logic [31:0]     res_q[$];
  int              due_q[$];
  int              last_due = 0;
  logic [31:0]     acc = '0;
  int beats, writes, dones, busy_cycles, first_vld_cyc, done_cyc, st_cyc;
  int stall_mode = 0;
  bit inj = 1'b0;

  typedef struct {
    int sub; int out; int nb; int wb; int rb;
    int smode; int restart; int exp_beats; int exp_writes;
  } vec_t;

  function automatic logic [31:0] fn_n(input logic [AW-1:0] a);
    return ({22'd0, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] fn_w(input logic [AW-1:0] a);
    return ({22'd0, a} * 32'h85EB_CA6B) ^ 32'h0F0F_3C3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor, buffer models, stand-in PE ----------------
  initial begin
    logic [31:0] d;
    int due;
    nbuf_rd_data = '0;
    wbuf_rd_data = '0;
    pe_res       = '0;
    pe_res_vld   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pe_res_vld = 1'b0;
        continue;
      end
      if (nbuf_rd_en || wbuf_rd_en) begin
        check("rd_en_pair", 64'(nbuf_rd_en), 64'(wbuf_rd_en));
        if (exp_rd_q.size() == 0) check("rd_extra", 64'(1), 64'(0));
        else check("rd_addr", 64'({nbuf_rd_addr, wbuf_rd_addr}), 64'(exp_rd_q.pop_front()));
      end
      if (pe_vld) begin
        beats++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (exp_ctrl_q.size() == 0) check("beat_extra", 64'(1), 64'(0));
        else check("pe_ctrl", 64'(pe_ctrl), 64'(exp_ctrl_q.pop_front()));
        if (pe_ctrl[0]) acc = '0;
        acc = acc + (pe_neuron[31:0] ^ pe_weight[DW-1:DW-32]);
        if (pe_ctrl[1]) begin
          due = cyc + int'($urandom_range(1, 4));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          res_q.push_back(acc);
          due_q.push_back(due);
        end
      end else if (busy) begin
        check("ctrl_bubble", 64'(pe_ctrl), 64'(0));
      end
      if (res_wr_en) begin
        writes++;
        if (exp_wr_q.size() == 0) check("wr_extra", 64'(1), 64'(0));
        else check("res_wr", 64'({res_wr_addr, res_wr_data}), 64'(exp_wr_q.pop_front()));
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (busy) busy_cycles++;
      if (nbuf_rd_en) nbuf_rd_data = {16{fn_n(nbuf_rd_addr)}};
      if (wbuf_rd_en) wbuf_rd_data = {16{fn_w(wbuf_rd_addr)}};
      pe_res_vld = inj;
      if (!inj && res_q.size() > 0 && due_q[0] <= cyc) begin
        d = res_q.pop_front();
        void'(due_q.pop_front());
        pe_res_vld = 1'b1;
        pe_res     = d;
      end
    end
  end

  // ---------------- stall driver (stable for a whole cycle) ----------------
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (cyc == st_cyc + 2) || (cyc == st_cyc + 4);
        default: stall = 1'b0;
      endcase
    end
  end

  // ---------------- reference model: job -> expected reads/ctrl/writes ----------------
  task automatic build_model(input int sub, input int out, input int nb, input int wb, input int rb);
    int se;
    logic [AW-1:0] na, wa, ra;
    logic [31:0] a;
    se = (sub == 0) ? 1 : sub;
    for (int o = 0; o < out; o++) begin
      a = '0;
      for (int s = 0; s < se; s++) begin
        na = AW'(nb + s);
        wa = AW'(wb + o * se + s);
        exp_rd_q.push_back({na, wa});
        exp_ctrl_q.push_back({(s == se - 1), (s == 0)});
        a = a + (fn_n(na) ^ fn_w(wa));
      end
      ra = AW'(rb + o);
      exp_wr_q.push_back({ra, a});
    end
  endtask

  task automatic clear_model();
    exp_rd_q.delete();
    exp_ctrl_q.delete();
    exp_wr_q.delete();
    res_q.delete();
    due_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_job(input int sub, input int out, input int nb, input int wb, input int rb,
                           input int smode);
    beats = 0; writes = 0; dones = 0; busy_cycles = 0;
    first_vld_cyc = -1; done_cyc = -1;
    @(negedge clk);
    stall_mode  = smode;
    cfg_sub_num = CW'(sub);
    cfg_out_num = CW'(out);
    cfg_nbase   = AW'(nb);
    cfg_wbase   = AW'(wb);
    cfg_rbase   = AW'(rb);
    start       = 1'b1;
    st_cyc      = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    build_model(v.sub, v.out, v.nb, v.wb, v.rb);
    start_job(v.sub, v.out, v.nb, v.wb, v.rb, v.smode);
    if (v.restart != 0) begin
      repeat (2) @(negedge clk);
      cfg_sub_num = 8'd7; cfg_out_num = 8'd9;
      cfg_nbase = 10'd11; cfg_wbase = 10'd500; cfg_rbase = 10'd700;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && dones == 0; i++) @(posedge clk);
    check("done_seen", 64'(dones > 0), 64'(1));
    repeat (6) @(negedge clk);
    check("done_count", 64'(dones), 64'(1));
    check("beats", 64'(beats), 64'(v.exp_beats));
    check("writes", 64'(writes), 64'(v.exp_writes));
    check("rd_left", 64'(exp_rd_q.size()), 64'(0));
    check("wr_left", 64'(exp_wr_q.size()), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
    if (v.out == 0) begin
      check("empty_done_lat", 64'(done_cyc - st_cyc), 64'(2));
      check("empty_busy_len", 64'(busy_cycles), 64'(2));
    end else if (v.smode == 0) begin
      check("first_vld_lat", 64'(first_vld_cyc - st_cyc), 64'(2));
    end
    stall_mode = 0;
    clear_model();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rd_en"}, 64'({nbuf_rd_en, wbuf_rd_en}), 64'(0));
    check({tag, "_pe_vld"}, 64'(pe_vld), 64'(0));
    check({tag, "_pe_ctrl"}, 64'(pe_ctrl), 64'(0));
    check({tag, "_wr_en"}, 64'(res_wr_en), 64'(0));
    check({tag, "_addrs"}, 64'({nbuf_rd_addr, wbuf_rd_addr, res_wr_addr}), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[7];
    vec_t rv;
    vecs[0] = '{4, 1,    0,   16,  100, 0, 0,  4, 1};
    vecs[1] = '{1, 3,    5,   40,  200, 0, 0,  3, 3};
    vecs[2] = '{3, 2,    7,   60,  300, 2, 0,  6, 2};
    vecs[3] = '{3, 0,    0,    0,    0, 0, 0,  0, 0};
    vecs[4] = '{4, 3,    2,   80,  400, 0, 1, 12, 3};
    vecs[5] = '{0, 2,    9,   90,  500, 0, 0,  2, 2};
    vecs[6] = '{3, 3, 1022, 1020, 1022, 0, 0,  9, 3};

    rst_n = 1'b0; start = 1'b0;
    cfg_sub_num = '0; cfg_out_num = '0;
    cfg_nbase = '0; cfg_wbase = '0; cfg_rbase = '0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // result pulse while idle must not produce a write
    writes = 0;
    @(negedge clk);
    inj = 1'b1;
    pe_res = 32'hDEAD_BEEF;
    @(negedge clk);
    inj = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_res_ignored", 64'(writes), 64'(0));

    // reset in the middle of ISSUE, then a clean job from the base addresses
    build_model(8, 4, 30, 130, 230);
    start_job(8, 4, 30, 130, 230, 0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{2, 3, 30, 130, 230, 0, 0, 6, 3};
    run_job(rv);

    // randomized jobs
    for (int i = 0; i < 10; i++) begin
      rv.sub = int'($urandom_range(0, 6));
      rv.out = int'($urandom_range(0, 5));
      rv.nb = int'($urandom_range(0, 1023));
      rv.wb = int'($urandom_range(0, 1023));
      rv.rb = int'($urandom_range(0, 1023));
      rv.smode = int'($urandom_range(0, 1));
      rv.restart = int'($urandom_range(0, 1));
      rv.exp_beats = ((rv.sub == 0) ? 1 : rv.sub) * rv.out;
      rv.exp_writes = rv.out;
      if (rv.out < 2) rv.restart = 0;
      if (rv.out == 0) rv.smode = 0;
      run_job(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
